// File: rtl/measure_pkg.sv
// Shared types, Ethernet length limits and small arithmetic helpers for the
// measure traffic tester transmit path.
package measure_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } tx_sched_state_t;

  localparam logic [15:0] ETH_MIN_LEN = 16'd64;
  localparam logic [15:0] ETH_MAX_LEN = 16'd1518;
  localparam logic [15:0] ARP_LEN     = 16'd64;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    logic [15:0] res;
    if (len < ETH_MIN_LEN) begin
      res = ETH_MIN_LEN;
    end else if (len > ETH_MAX_LEN) begin
      res = ETH_MAX_LEN;
    end else begin
      res = len;
    end
    return res;
  endfunction

  // Byte gap to 8-byte XGMII words, rounded up; 33-bit sum keeps 32'hFFFF_FFFF exact.
  function automatic logic [29:0] gap_cycles(input logic [31:0] ifg);
    logic [29:0] words;
    words = 30'(({1'b0, ifg} + 33'd7) >> 3);
    if (words == 30'd0) begin
      words = 30'd1;
    end else begin
      words = words;
    end
    return words;
  endfunction

endpackage

// File: rtl/rate_window.sv
// Per-window frame and byte rate counters with saturating accumulators and
// output latches that hold the last complete window.
module rate_window #(
  parameter int unsigned TICKS_PER_SEC = 156_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [15:0] frame_bytes,
  output logic [31:0] pps,
  output logic [31:0] throughput
);

  localparam logic [31:0] TICK_LAST = 32'(TICKS_PER_SEC - 1);

  logic [31:0] tick;
  logic [31:0] frame_acc;
  logic [31:0] byte_acc;
  logic        wrap;
  logic [31:0] frame_inc;
  logic [31:0] byte_inc;
  logic [31:0] frame_next;
  logic [31:0] byte_next;
  logic [32:0] byte_sum;

  assign wrap      = (tick == TICK_LAST);
  assign frame_inc = frame_valid ? 32'd1 : 32'd0;
  assign byte_inc  = frame_valid ? {16'd0, frame_bytes} : 32'd0;
  assign byte_sum  = {1'b0, byte_acc} + {1'b0, byte_inc};

  always_comb begin
    frame_next = frame_acc;
    byte_next  = byte_acc;
    if (frame_acc == 32'hFFFF_FFFF) begin
      frame_next = frame_acc;
    end else begin
      frame_next = frame_acc + frame_inc;
    end
    if (byte_sum[32]) begin
      byte_next = 32'hFFFF_FFFF;
    end else begin
      byte_next = byte_sum[31:0];
    end
  end

  // On the wrap cycle the finished window is latched and this cycle's frame opens the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick       <= 32'd0;
      frame_acc  <= 32'd0;
      byte_acc   <= 32'd0;
      pps        <= 32'd0;
      throughput <= 32'd0;
    end else if (wrap) begin
      tick       <= 32'd0;
      frame_acc  <= frame_inc;
      byte_acc   <= byte_inc;
      pps        <= frame_acc;
      throughput <= byte_acc;
    end else begin
      tick       <= tick + 32'd1;
      frame_acc  <= frame_next;
      byte_acc   <= byte_next;
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frame scheduler for the port-0 XGMII transmit generator: ARP/test arbitration,
// inter-frame gap, generator watchdog and per-window rate reporting.
module tx_frame_scheduler
  import measure_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 156_250_000,
  parameter int unsigned WDOG_CYCLES   = 4096
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_enable,
  input  logic        req_arp,
  input  logic [15:0] frame_len,
  input  logic [31:0] inter_frame_gap,
  output logic        gen_start,
  output logic        gen_arp,
  output logic [15:0] gen_len,
  input  logic        gen_done,
  output logic        busy,
  output logic        wdog_err,
  output logic [31:0] tx_pps,
  output logic [31:0] tx_throughput
);

  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  tx_sched_state_t state;
  tx_sched_state_t next_state;
  logic        arp_pend;
  logic        req_arp_q;
  logic        arp_rise;
  logic [29:0] gap_cnt;
  logic [31:0] wdog_cnt;
  logic        start_frame;
  logic        start_arp;
  logic        load_gap;
  logic        abort;

  assign arp_rise = req_arp & ~req_arp_q;

  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    start_arp   = 1'b0;
    load_gap    = 1'b0;
    abort       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arp_pend || tx_enable) begin
          next_state  = ST_START;
          start_frame = 1'b1;
          start_arp   = arp_pend;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_START: next_state = ST_SEND;
      ST_SEND: begin
        // A done on the terminal watchdog cycle still counts as a clean finish.
        if (gen_done) begin
          next_state = ST_GAP;
          load_gap   = 1'b1;
        end else if (wdog_cnt == WDOG_LAST) begin
          next_state = ST_GAP;
          load_gap   = 1'b1;
          abort      = 1'b1;
        end else begin
          next_state = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt <= 30'd1) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_GAP;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Control state, ARP request capture, gap and watchdog counters.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      arp_pend  <= 1'b0;
      req_arp_q <= 1'b0;
      gap_cnt   <= 30'd0;
      wdog_cnt  <= 32'd0;
    end else begin
      state     <= next_state;
      req_arp_q <= req_arp;
      arp_pend  <= arp_rise | (arp_pend & ~start_arp);
      if (load_gap) begin
        gap_cnt <= gap_cycles(inter_frame_gap);
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt - 30'd1;
      end else begin
        gap_cnt <= gap_cnt;
      end
      if (start_frame) begin
        wdog_cnt <= 32'd0;
      end else if (state == ST_START || state == ST_SEND) begin
        wdog_cnt <= wdog_cnt + 32'd1;
      end else begin
        wdog_cnt <= wdog_cnt;
      end
    end
  end

  // Generator handshake outputs are one-cycle pulses aligned with the START state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gen_start <= 1'b0;
      gen_arp   <= 1'b0;
      gen_len   <= 16'd0;
      busy      <= 1'b0;
      wdog_err  <= 1'b0;
    end else begin
      gen_start <= start_frame;
      gen_arp   <= start_frame & start_arp;
      if (start_frame) begin
        gen_len <= start_arp ? ARP_LEN : clamp_len(frame_len);
      end else begin
        gen_len <= 16'd0;
      end
      busy     <= (next_state != ST_IDLE);
      wdog_err <= wdog_err | abort;
    end
  end

  rate_window #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_rate_window (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .frame_valid(gen_start & ~gen_arp),
    .frame_bytes(gen_len),
    .pps        (tx_pps),
    .throughput (tx_throughput)
  );

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a simple generator model that
// returns gen_done a programmable number of cycles after gen_start.
module tb_tx_frame_scheduler;
  import measure_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        tx_enable;
  logic        req_arp;
  logic [15:0] frame_len;
  logic [31:0] inter_frame_gap;
  logic        gen_start;
  logic        gen_arp;
  logic [15:0] gen_len;
  logic        gen_done;
  logic        busy;
  logic        wdog_err;
  logic [31:0] tx_pps;
  logic [31:0] tx_throughput;

  logic        model_en;
  logic [7:0]  done_dly;
  logic [7:0]  dly;
  int          cyc;
  int          vectors = 0;
  int          miscompares = 0;
  int          n;
  int          cnt;

  tx_frame_scheduler #(
    .TICKS_PER_SEC(100),
    .WDOG_CYCLES  (16)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .tx_enable      (tx_enable),
    .req_arp        (req_arp),
    .frame_len      (frame_len),
    .inter_frame_gap(inter_frame_gap),
    .gen_start      (gen_start),
    .gen_arp        (gen_arp),
    .gen_len        (gen_len),
    .gen_done       (gen_done),
    .busy           (busy),
    .wdog_err       (wdog_err),
    .tx_pps         (tx_pps),
    .tx_throughput  (tx_throughput)
  );

  always #5 sys_clk = ~sys_clk;

  // Generator model: gen_done lands done_dly cycles after the gen_start cycle.
  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) dly <= 8'd0;
    else if (gen_start && model_en) dly <= done_dly;
    else if (dly != 8'd0) dly <= dly - 8'd1;
  end
  assign gen_done = (dly == 8'd1);

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge sys_clk);
      cycles++;
    end while (!gen_start && cycles < budget);
  endtask

  task automatic count_starts(input int span, output int starts);
    starts = 0;
    for (int i = 0; i < span; i++) begin
      @(negedge sys_clk);
      if (gen_start) starts++;
    end
  endtask

  initial begin
    sys_rst = 1'b1; tx_enable = 1'b0; req_arp = 1'b0;
    frame_len = 16'd68; inter_frame_gap = 32'd12;
    model_en = 1'b1; done_dly = 8'd9;
    repeat (2) @(negedge sys_clk);
    chk("rst_gen_start", 64'(gen_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wdog", 64'(wdog_err), 64'd0);
    chk("rst_pps", 64'(tx_pps), 64'd0);
    tx_enable = 1'b1;
    sys_rst = 1'b0;

    // Steady traffic: first start after one IDLE->START edge, then every 13 cycles.
    @(negedge sys_clk);
    chk("first_start", 64'(gen_start), 64'd1);
    chk("first_len", 64'(gen_len), 64'd68);
    chk("first_arp", 64'(gen_arp), 64'd0);
    chk("first_busy", 64'(busy), 64'd1);
    wait_start(40, n);
    chk("period_a", 64'(n), 64'd13);
    wait_start(40, n);
    chk("period_b", 64'(n), 64'd13);
    chk("steady_len", 64'(gen_len), 64'd68);

    // Window 1 (ticks 0..99): starts at cycles 1,14,..,92 -> 8 frames.
    while (cyc < 99) @(negedge sys_clk);
    chk("pps_before_wrap", 64'(tx_pps), 64'd0);
    @(negedge sys_clk);
    chk("pps_win1", 64'(tx_pps), 64'd8);
    chk("thr_win1", 64'(tx_throughput), 64'd544);

    // Two ARP edges during one SEND merge into a single ARP frame.
    wait_start(40, n);
    @(negedge sys_clk); req_arp = 1'b1;
    @(negedge sys_clk); req_arp = 1'b0;
    @(negedge sys_clk); req_arp = 1'b1;
    @(negedge sys_clk); req_arp = 1'b0;
    wait_start(40, n);
    chk("arp_gap", 64'(n), 64'd9);
    chk("arp_flag", 64'(gen_arp), 64'd1);
    chk("arp_len", 64'(gen_len), 64'd64);
    wait_start(40, n);
    chk("post_arp_period", 64'(n), 64'd13);
    chk("post_arp_flag", 64'(gen_arp), 64'd0);
    chk("post_arp_len", 64'(gen_len), 64'd68);
    wait_start(40, n);
    chk("single_arp_flag", 64'(gen_arp), 64'd0);

    // Window 2: 7 test frames plus one uncounted ARP frame.
    while (cyc < 199) @(negedge sys_clk);
    chk("pps_hold", 64'(tx_pps), 64'd8);
    @(negedge sys_clk);
    chk("pps_win2", 64'(tx_pps), 64'd7);
    chk("thr_win2", 64'(tx_throughput), 64'd476);

    // Length clamps and gap extremes.
    frame_len = 16'd40;
    wait_start(40, n);
    chk("clamp_low", 64'(gen_len), 64'd64);
    frame_len = 16'd2000;
    wait_start(40, n);
    chk("clamp_high", 64'(gen_len), 64'd1518);
    frame_len = 16'd68;
    inter_frame_gap = 32'd0;
    wait_start(40, n);
    chk("gap_zero_period", 64'(n), 64'd12);
    inter_frame_gap = 32'hFFFF_FFFF;
    repeat (10) @(negedge sys_clk);
    chk("gap_max_load", 64'(dut.gap_cnt), 64'd536870912);
    chk("gap_max_busy", 64'(busy), 64'd1);

    // Asynchronous reset inside a long gap clears windows and outputs at once.
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pps", 64'(tx_pps), 64'd0);
    chk("arst_thr", 64'(tx_throughput), 64'd0);
    chk("arst_state", 64'(dut.state), 64'(ST_IDLE));
    inter_frame_gap = 32'd12;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Enable drop mid-frame: frame and gap finish, then the block idles.
    wait_start(10, n);
    chk("drop_start", 64'(gen_start), 64'd1);
    tx_enable = 1'b0;
    repeat (11) @(negedge sys_clk);
    chk("drop_gap_busy", 64'(busy), 64'd1);
    @(negedge sys_clk);
    chk("drop_idle_busy", 64'(busy), 64'd0);
    count_starts(30, cnt);
    chk("drop_no_restart", 64'(cnt), 64'd0);

    // ARP is sent even with test traffic disabled.
    req_arp = 1'b1;
    wait_start(20, n);
    chk("arp_dis_flag", 64'(gen_arp), 64'd1);
    chk("arp_dis_len", 64'(gen_len), 64'd64);
    req_arp = 1'b0;
    count_starts(30, cnt);
    chk("arp_dis_once", 64'(cnt), 64'd0);

    // Reset in the middle of SEND.
    tx_enable = 1'b1;
    wait_start(20, n);
    repeat (3) @(negedge sys_clk);
    chk("send_busy", 64'(busy), 64'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("send_rst_busy", 64'(busy), 64'd0);
    chk("send_rst_state", 64'(dut.state), 64'(ST_IDLE));
    done_dly = 8'd15;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;

    // gen_done on the watchdog terminal cycle is a normal finish.
    wait_start(10, n);
    wait_start(40, n);
    chk("term_period", 64'(n), 64'd19);
    chk("term_no_wdog", 64'(wdog_err), 64'd0);

    // Generator never answers: abort after 16 cycles, gap, then the next frame.
    model_en = 1'b0;
    repeat (15) @(negedge sys_clk);
    chk("wdog_before", 64'(wdog_err), 64'd0);
    @(negedge sys_clk);
    chk("wdog_set", 64'(wdog_err), 64'd1);
    wait_start(40, n);
    chk("wdog_restart", 64'(n), 64'd3);
    chk("wdog_sticky", 64'(wdog_err), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
